four_bool_fitness_eval: RTL and testbench
=========================================

# four_bool_fitness_eval

Sequential fitness evaluator that sits directly upstream and downstream of a candidate `fourBool` circuit. On `start` it drives all 16 combinations of the four Boolean inputs into the candidate, waits a programmable settle time for gate delays, and samples the four outputs. It compares each sample against a target truth table and accumulates a bit-level match score. The score is the fitness value handed to the evolution harness for each candidate netlist.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles each vector is held before sampling; legal range 1..255.
- `EXPECTED`, default 64'hFFFF_FFFF_FFFF_FFFF: target truth table; bits [4i+3:4i] give the expected {output3,output2,output1,output0} for input vector i.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  sweep request; sampled only in IDLE.
- `dut_in`  out  4  drives {input3,input2,input1,input0} of the candidate.
- `dut_out`  in  4  {output3,output2,output1,output0} from the candidate.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `score`  out  7  count of matching output bits, 0..64.
- `mismatch_mask`  out  16  bit i set if vector i had any mismatching output bit.
- `perfect`  out  1  high when `score` == 64.

## Operation
- Reset values: state IDLE, `dut_in`=0, `busy`=0, `done`=0, `score`=0, `mismatch_mask`=0, `perfect`=0.
- The FSM has four states: IDLE, SETTLE, SAMPLE and DONE.
- IDLE:
  - `start`=1 clears `score`, `mismatch_mask` and `perfect`.
  - It also sets vector index v=0, `dut_in`=0, and the settle counter to SETTLE_CYCLES.
  - Next state is SETTLE.
- SETTLE:
  - The counter decrements once per cycle.
  - When the counter reaches 1, next state is SAMPLE.
  - The state lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - Compute x = `dut_out` XOR `EXPECTED`[4v+3:4v].
  - Update `score` += 4 − popcount(x) and set `mismatch_mask`[v] = |x.
  - If v==15, next state is DONE.
  - Otherwise v and `dut_in` increment, the counter reloads, and next state is SETTLE.
- DONE (1 cycle):
  - `done`=1 and `perfect` = (`score`==64).
  - Next state is IDLE.
- Result hold: `score`, `mismatch_mask` and `perfect` hold their values in IDLE until the next accepted `start`.
- Arithmetic: `score` is 7 bits wide, cannot overflow (maximum 64), and the 3-bit increment is zero-extended.
- `start` handling: ignored in SETTLE, SAMPLE and DONE. No queuing, no abort. `start` held high re-launches a sweep on the IDLE cycle following DONE.
- Reset mid-sweep: immediately forces all reset values and drops the sweep. No `done` is produced and partial results are discarded.

## Timing
- `start` is captured at edge k; `busy` is high from edge k for 16·(SETTLE_CYCLES+1) cycles.
- `dut_in`=v is valid for SETTLE_CYCLES+1 cycles. `dut_out` is sampled in that window's final cycle (SAMPLE).
- `done` is high for exactly one cycle, immediately after `busy` falls. `busy` and `done` are never high together.
- Throughput with `start` held high is one sweep per 16·(SETTLE_CYCLES+1)+2 cycles.
- All outputs are registered. There is no combinational path from `dut_out` to any output.

## Test plan
- Default parameters (SETTLE_CYCLES=4), candidate outputs tied 4'hF, single `start` pulse:
  - `busy` is high for 80 cycles, then `done` pulses once.
  - `score`=64, `mismatch_mask`=16'h0000, `perfect`=1.
- Candidate outputs tied 4'h0, default EXPECTED:
  - `score`=0, `mismatch_mask`=16'hFFFF, `perfect`=0.
- EXPECTED set to the truth table {in3^in2, ~(in1&in0), 1, in1&in2} with a matching behavioral candidate:
  - `score`=64.
  - Then invert output3 only when `dut_in`=5: `score`=63, `mismatch_mask`=16'h0020, `perfect`=0.
- Vector sequencing with SETTLE_CYCLES=2:
  - `dut_in` steps 0..15, each held exactly 3 cycles.
  - A candidate model with 2-cycle output delay still scores 64.
  - With SETTLE_CYCLES=1, the same model fails with a nonzero mask.
- `start` pulsed at cycles 5 and 30 during a sweep:
  - Both pulses ignored; exactly one `done`.
  - `start` held high: back-to-back sweeps with one IDLE cycle between DONE and the next `busy`.
- `rst` asserted during the vector-7 SETTLE:
  - All outputs return to reset values asynchronously and no `done` is produced.
  - A following `start` yields the full correct result (64 with the tied-4'hF candidate).

Source files
------------

// File: rtl/four_bool_fitness_eval.sv
// Fitness evaluator for a four-input/four-output candidate circuit: sweeps all
// 16 input vectors, samples after a settle delay and scores bit matches.
module four_bool_fitness_eval #(
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [63:0] EXPECTED      = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  dut_in,
    input  logic [3:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic [6:0]  score,
    output logic [15:0] mismatch_mask,
    output logic        perfect
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_t     state;
    logic [7:0] settle_cnt;
    logic [3:0] diff;
    logic [2:0] gain;
    logic [6:0] score_nxt;

    // The vector index is dut_in itself, so the expected nibble is selected by it.
    always_comb begin
        diff      = dut_out ^ EXPECTED[{dut_in, 2'b00} +: 4];
        gain      = 3'd4 - ({2'b00, diff[0]} + {2'b00, diff[1]}
                          + {2'b00, diff[2]} + {2'b00, diff[3]});
        score_nxt = score + {4'b0000, gain};
    end

    // NOTE: all state is assigned with non-blocking (<=) so every register sees
    // pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            settle_cnt    <= '0;
            dut_in        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            score         <= '0;
            mismatch_mask <= '0;
            perfect       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        score         <= '0;
                        mismatch_mask <= '0;
                        perfect       <= 1'b0;
                        dut_in        <= '0;
                        settle_cnt    <= SETTLE_LOAD;
                        busy          <= 1'b1;
                        state         <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == 8'd1) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 8'd1;
                    end
                end
                SAMPLE: begin
                    score                 <= score_nxt;
                    mismatch_mask[dut_in] <= |diff;
                    if (dut_in == 4'd15) begin
                        // perfect uses the final score so it is valid alongside done.
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        perfect <= (score_nxt == 7'd64);
                        state   <= DONE;
                    end else begin
                        dut_in     <= dut_in + 4'd1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_four_bool_fitness_eval.sv
// Self-checking bench: three evaluator instances (default, SETTLE=2, SETTLE=1)
// with table-driven, randomized and hand-written multi-cycle scenarios.
module tb_four_bool_fitness_eval;

    function automatic logic [3:0] tt_f(input logic [3:0] n);
        return {n[3] ^ n[2], ~(n[1] & n[0]), 1'b1, n[1] & n[2]};
    endfunction

    function automatic logic [63:0] tt_build();
        logic [63:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) t[4*i +: 4] = tt_f(4'(i));
        return t;
    endfunction

    localparam logic [63:0] TT    = tt_build();
    localparam logic [63:0] EXP_A = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [1:0] sel = 2'd0;
    logic fault = 1'b0;
    logic [63:0] cand_tt = '1;

    logic [3:0] din_a, din_b, din_c, dout_a, dout_b, dout_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
    logic perf_a, perf_b, perf_c;
    logic [6:0] score_a, score_b, score_c;
    logic [15:0] mask_a, mask_b, mask_c;

    logic [3:0] din_m;
    logic busy_m, done_m, perf_m;
    logic [6:0] score_m;
    logic [15:0] mask_m;

    logic [3:0] b_d1 = '0, b_d2 = '0, c_d1 = '0, c_d2 = '0;

    int total = 0;
    int bad = 0;
    int overlap = 0;
    logic [3:0] seq_q[$];

    always #5 clk = ~clk;

    four_bool_fitness_eval u_a (
        .clk(clk), .rst(rst), .start(start && sel == 2'd0), .dut_in(din_a), .dut_out(dout_a),
        .busy(busy_a), .done(done_a), .score(score_a), .mismatch_mask(mask_a), .perfect(perf_a));

    four_bool_fitness_eval #(.SETTLE_CYCLES(2), .EXPECTED(TT)) u_b (
        .clk(clk), .rst(rst), .start(start && sel == 2'd1), .dut_in(din_b), .dut_out(dout_b),
        .busy(busy_b), .done(done_b), .score(score_b), .mismatch_mask(mask_b), .perfect(perf_b));

    four_bool_fitness_eval #(.SETTLE_CYCLES(1), .EXPECTED(TT)) u_c (
        .clk(clk), .rst(rst), .start(start && sel == 2'd2), .dut_in(din_c), .dut_out(dout_c),
        .busy(busy_c), .done(done_c), .score(score_c), .mismatch_mask(mask_c), .perfect(perf_c));

    // Candidate A is a combinational lookup; B and C have two cycles of output delay.
    assign dout_a = cand_tt[{din_a, 2'b00} +: 4];
    assign dout_b = b_d2;
    assign dout_c = c_d2;

    always @(posedge clk) begin
        b_d1 <= tt_f(din_b) ^ ((fault && din_b == 4'd5) ? 4'h8 : 4'h0);
        b_d2 <= b_d1;
        c_d1 <= tt_f(din_c);
        c_d2 <= c_d1;
    end

    always_comb begin
        din_m = din_a; busy_m = busy_a; done_m = done_a;
        score_m = score_a; mask_m = mask_a; perf_m = perf_a;
        if (sel == 2'd1) begin
            din_m = din_b; busy_m = busy_b; done_m = done_b;
            score_m = score_b; mask_m = mask_b; perf_m = perf_b;
        end else if (sel == 2'd2) begin
            din_m = din_c; busy_m = busy_c; done_m = done_c;
            score_m = score_c; mask_m = mask_c; perf_m = perf_c;
        end
    end

    always @(negedge clk) begin
        if ((busy_a && done_a) || (busy_b && done_b) || (busy_c && done_c)) overlap++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: count matching bits vector by vector against the target table.
    task automatic ref_eval(input logic [63:0] tt, input logic [63:0] expt,
                            output logic [6:0] sc, output logic [15:0] mk);
        int n;
        n = 0;
        mk = '0;
        for (int v = 0; v < 16; v++)
            for (int b = 0; b < 4; b++)
                if (tt[4*v+b] == expt[4*v+b]) n++;
                else mk[v] = 1'b1;
        sc = 7'(n);
    endtask

    // One start pulse; returns busy-cycle count and done pulses seen after busy fell.
    task automatic sweep(output int bc, output int dc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        bc = 0;
        dc = 0;
        seq_q.delete();
        while (busy_m && bc < 2000) begin
            bc++;
            seq_q.push_back(din_m);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            if (done_m) dc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [63:0] tt;
        logic [6:0]  score;
        logic [15:0] mask;
        logic        perfect;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bc, dc, errs, d1, d2, b_after;
        logic pd;
        logic [6:0] rsc;
        logic [15:0] rmk;

        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd64, 16'h0000, 1'b1};
        tbl[1] = '{64'h0000_0000_0000_0000, 7'd0,  16'hFFFF, 1'b0};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 7'd63, 16'h0001, 1'b0};
        tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 7'd63, 16'h8000, 1'b0};
        tbl[4] = '{64'hF0F0_F0F0_F0F0_F0F0, 7'd32, 16'h5555, 1'b0};
        tbl[5] = '{64'h8888_8888_8888_8888, 7'd16, 16'hFFFF, 1'b0};

        #12;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_score", score_a, 0);
        check("rst_mask", mask_a, 0);
        check("rst_perfect", perf_a, 0);
        check("rst_dut_in", din_a, 0);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven: tied-F, tied-0 and assorted candidate truth tables.
        sel = 2'd0;
        for (int i = 0; i < 6; i++) begin
            cand_tt = tbl[i].tt;
            sweep(bc, dc);
            check($sformatf("tbl%0d_busy", i), 64'(bc), 80);
            check($sformatf("tbl%0d_done", i), 64'(dc), 1);
            check($sformatf("tbl%0d_score", i), score_m, tbl[i].score);
            check($sformatf("tbl%0d_mask", i), mask_m, tbl[i].mask);
            check($sformatf("tbl%0d_perfect", i), perf_m, tbl[i].perfect);
        end

        // Randomized candidates against the reference model.
        for (int i = 0; i < 8; i++) begin
            cand_tt = {$urandom, $urandom};
            ref_eval(cand_tt, EXP_A, rsc, rmk);
            sweep(bc, dc);
            check($sformatf("rnd%0d_score", i), score_m, rsc);
            check($sformatf("rnd%0d_mask", i), mask_m, rmk);
            check($sformatf("rnd%0d_perfect", i), perf_m, rsc == 7'd64);
        end

        // start pulses in mid-sweep are ignored.
        cand_tt = '1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        bc = 0;
        dc = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy_m) bc++;
            if (done_m) dc++;
            start = (i == 5 || i == 30);
            @(negedge clk);
        end
        check("ignore_busy", 64'(bc), 80);
        check("ignore_done", 64'(dc), 1);
        check("ignore_score", score_m, 64);

        // start held high: back-to-back sweeps with one IDLE cycle in between.
        d1 = -1; d2 = -1; b_after = -1; pd = 1'b0;
        @(negedge clk); start = 1'b1;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (done_m && !pd) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
            if (d1 >= 0 && b_after < 0 && i > d1 && busy_m) b_after = i;
            pd = done_m;
        end
        start = 1'b0;
        check("b2b_period", 64'(d2 - d1), 82);
        check("b2b_restart", 64'(b_after - d1), 2);
        errs = 0;
        while ((busy_m || done_m) && errs < 300) begin
            errs++;
            @(negedge clk);
        end
        check("b2b_drain", 64'(busy_m || done_m), 0);

        // Asynchronous reset during the vector-7 settle.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        errs = 0;
        while (din_m != 4'd7 && errs < 500) begin
            errs++;
            @(negedge clk);
        end
        check("rst7_reach", din_m, 7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst7_busy", busy_m, 0);
        check("rst7_done", done_m, 0);
        check("rst7_score", score_m, 0);
        check("rst7_mask", mask_m, 0);
        check("rst7_perfect", perf_m, 0);
        check("rst7_dut_in", din_m, 0);
        dc = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_m) dc++;
        end
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (done_m) dc++;
        end
        check("rst7_no_done", 64'(dc), 0);
        sweep(bc, dc);
        check("rst7_after_score", score_m, 64);
        check("rst7_after_perfect", perf_m, 1);

        // SETTLE_CYCLES=2, delayed candidate: sequencing and full score, then one fault.
        sel = 2'd1;
        sweep(bc, dc);
        check("s2_busy", 64'(bc), 48);
        check("s2_done", 64'(dc), 1);
        errs = 0;
        for (int i = 0; i < seq_q.size(); i++)
            if (seq_q[i] !== 4'(i / 3)) errs++;
        check("s2_seq_len", 64'(seq_q.size()), 48);
        check("s2_seq_errs", 64'(errs), 0);
        check("s2_score", score_m, 64);
        check("s2_mask", mask_m, 16'h0000);
        check("s2_perfect", perf_m, 1);
        fault = 1'b1;
        sweep(bc, dc);
        fault = 1'b0;
        check("s2f_score", score_m, 63);
        check("s2f_mask", mask_m, 16'h0020);
        check("s2f_perfect", perf_m, 0);

        // SETTLE_CYCLES=1: the same delayed candidate is sampled too early.
        sel = 2'd2;
        sweep(bc, dc);
        check("s1_busy", 64'(bc), 32);
        check("s1_mask_nonzero", 64'(mask_m != 16'h0000), 1);
        check("s1_score_lt64", 64'(score_m < 7'd64), 1);
        check("s1_perfect", perf_m, 0);

        check("busy_done_overlap", 64'(overlap), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
